// File: rtl/avr_lsu.sv
// Data-space load/store unit: effective-address generation, REG/IO/SRAM decode,
// one-cycle bus strobe, load writeback and pointer writeback for LD/ST via X/Y/Z.
module avr_lsu #(
   parameter logic [15:0]  IO_BASE = 16'h0020,
   parameter int unsigned  IO_SIZE = 64,
   parameter logic [15:0]  REG_TOP = 16'h001F
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [1:0]  req_mode,
   input  logic [15:0] req_ptr,
   input  logic [5:0]  req_disp,
   input  logic [7:0]  req_wdata,
   input  logic [4:0]  req_rd,
   output logic        busy,
   output logic [15:0] d_addr,
   output logic        d_re,
   output logic        d_we,
   output logic [7:0]  d_wdata,
   input  logic [7:0]  d_rdata,
   output logic        io_sel,
   output logic [5:0]  io_addr,
   input  logic [7:0]  io_rdata,
   output logic        rd_we,
   output logic [4:0]  rd_addr,
   output logic [7:0]  rd_data,
   output logic        ptr_we,
   output logic [15:0] ptr_new,
   output logic        addr_fault
);

   localparam int unsigned AW = 16;
   localparam int unsigned DW = 8;

   localparam logic [1:0] MODE_PLAIN = 2'b00;
   localparam logic [1:0] MODE_POST  = 2'b01;
   localparam logic [1:0] MODE_PRE   = 2'b10;

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
   typedef enum logic [1:0] {R_SRAM, R_IO, R_REG} region_t;

   state_t        state_q, state_d;
   region_t       region_q, region_d;
   logic          we_q, we_d;
   logic [4:0]    rd_q, rd_d;
   logic [AW-1:0] d_addr_q, d_addr_d;
   logic [5:0]    io_addr_q, io_addr_d;
   logic [DW-1:0] d_wdata_q, d_wdata_d;
   logic          d_re_q, d_re_d;
   logic          d_we_q, d_we_d;
   logic          io_sel_q, io_sel_d;
   logic          ptr_we_q, ptr_we_d;
   logic [AW-1:0] ptr_new_q, ptr_new_d;
   logic          fault_q, fault_d;
   logic          rd_we_q, rd_we_d;
   logic [4:0]    rd_addr_q, rd_addr_d;
   logic [DW-1:0] rd_data_q, rd_data_d;

   logic [AW-1:0] ptr_inc, ptr_dec, ea;
   logic [AW:0]   io_end;
   logic          ea_is_io;
   region_t       ea_region;
   logic [DW-1:0] rd_live;

   // Effective address and region of the request presented on the inputs
   always_comb begin
      ptr_inc = req_ptr + 16'd1;
      ptr_dec = req_ptr - 16'd1;
      unique case (req_mode)
         MODE_PLAIN: ea = req_ptr;
         MODE_POST:  ea = req_ptr;
         MODE_PRE:   ea = ptr_dec;
         default:    ea = req_ptr + {10'd0, req_disp};
      endcase
      io_end   = {1'b0, IO_BASE} + 17'(IO_SIZE);
      ea_is_io = ({1'b0, ea} >= {1'b0, IO_BASE}) && ({1'b0, ea} < io_end);
      if (ea <= REG_TOP)  ea_region = R_REG;
      else if (ea_is_io)  ea_region = R_IO;
      else                ea_region = R_SRAM;
   end

   // Load data is only valid in the RESP cycle, so it is passed through there
   always_comb begin
      unique case (region_q)
         R_IO:    rd_live = io_rdata;
         R_SRAM:  rd_live = d_rdata;
         default: rd_live = 8'h00;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      region_d   = region_q;
      we_d       = we_q;
      rd_d       = rd_q;
      d_addr_d   = d_addr_q;
      io_addr_d  = io_addr_q;
      d_wdata_d  = d_wdata_q;
      ptr_new_d  = ptr_new_q;
      rd_addr_d  = rd_addr_q;
      rd_data_d  = rd_data_q;
      d_re_d     = 1'b0;
      d_we_d     = 1'b0;
      io_sel_d   = 1'b0;
      ptr_we_d   = 1'b0;
      fault_d    = 1'b0;
      rd_we_d    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               state_d   = S_ACCESS;
               region_d  = ea_region;
               we_d      = req_we;
               rd_d      = req_rd;
               d_addr_d  = ea;
               io_addr_d = 6'(ea - IO_BASE);
               d_wdata_d = req_wdata;
               d_re_d    = !req_we && (ea_region != R_REG);
               d_we_d    = req_we && (ea_region != R_REG);
               io_sel_d  = (ea_region == R_IO);
               fault_d   = (ea_region == R_REG);
               if (req_mode == MODE_POST) begin
                  ptr_we_d  = 1'b1;
                  ptr_new_d = ptr_inc;
               end else if (req_mode == MODE_PRE) begin
                  ptr_we_d  = 1'b1;
                  ptr_new_d = ptr_dec;
               end
            end
         end
         S_ACCESS: begin
            if (we_q) begin
               state_d = S_IDLE;
            end else begin
               state_d   = S_RESP;
               rd_we_d   = 1'b1;
               rd_addr_d = rd_q;
            end
         end
         S_RESP: begin
            state_d   = S_IDLE;
            rd_data_d = rd_live;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= S_IDLE;
         region_q  <= R_SRAM;
         we_q      <= 1'b0;
         rd_q      <= '0;
         d_addr_q  <= '0;
         io_addr_q <= '0;
         d_wdata_q <= '0;
         d_re_q    <= 1'b0;
         d_we_q    <= 1'b0;
         io_sel_q  <= 1'b0;
         ptr_we_q  <= 1'b0;
         ptr_new_q <= '0;
         fault_q   <= 1'b0;
         rd_we_q   <= 1'b0;
         rd_addr_q <= '0;
         rd_data_q <= '0;
      end else begin
         state_q   <= state_d;
         region_q  <= region_d;
         we_q      <= we_d;
         rd_q      <= rd_d;
         d_addr_q  <= d_addr_d;
         io_addr_q <= io_addr_d;
         d_wdata_q <= d_wdata_d;
         d_re_q    <= d_re_d;
         d_we_q    <= d_we_d;
         io_sel_q  <= io_sel_d;
         ptr_we_q  <= ptr_we_d;
         ptr_new_q <= ptr_new_d;
         fault_q   <= fault_d;
         rd_we_q   <= rd_we_d;
         rd_addr_q <= rd_addr_d;
         rd_data_q <= rd_data_d;
      end
   end

   assign busy       = (state_q != S_IDLE);
   assign d_addr     = d_addr_q;
   assign io_addr    = io_addr_q;
   assign d_wdata    = d_wdata_q;
   assign d_re       = d_re_q;
   assign d_we       = d_we_q;
   assign io_sel     = io_sel_q;
   assign ptr_we     = ptr_we_q;
   assign ptr_new    = ptr_new_q;
   assign addr_fault = fault_q;
   assign rd_we      = rd_we_q;
   assign rd_addr    = rd_addr_q;
   assign rd_data    = (state_q == S_RESP) ? rd_live : rd_data_q;

endmodule

// File: tb/tb_avr_lsu.sv
// Directed self-checking bench for avr_lsu: address modes, region decode,
// wrap cases, reset mid-load and request acceptance rate.
module tb_avr_lsu;

   logic        CLK = 1'b0;
   logic        RST;
   logic        req_valid;
   logic        req_we;
   logic [1:0]  req_mode;
   logic [15:0] req_ptr;
   logic [5:0]  req_disp;
   logic [7:0]  req_wdata;
   logic [4:0]  req_rd;
   logic        busy;
   logic [15:0] d_addr;
   logic        d_re;
   logic        d_we;
   logic [7:0]  d_wdata;
   logic [7:0]  d_rdata;
   logic        io_sel;
   logic [5:0]  io_addr;
   logic [7:0]  io_rdata;
   logic        rd_we;
   logic [4:0]  rd_addr;
   logic [7:0]  rd_data;
   logic        ptr_we;
   logic [15:0] ptr_new;
   logic        addr_fault;

   int n_cmp = 0;
   int n_bad = 0;

   avr_lsu dut (
      .CLK(CLK), .RST(RST),
      .req_valid(req_valid), .req_we(req_we), .req_mode(req_mode),
      .req_ptr(req_ptr), .req_disp(req_disp), .req_wdata(req_wdata), .req_rd(req_rd),
      .busy(busy), .d_addr(d_addr), .d_re(d_re), .d_we(d_we), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .io_sel(io_sel), .io_addr(io_addr), .io_rdata(io_rdata),
      .rd_we(rd_we), .rd_addr(rd_addr), .rd_data(rd_data),
      .ptr_we(ptr_we), .ptr_new(ptr_new), .addr_fault(addr_fault)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one edge and settle just after it
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Present a request for exactly one edge; returns in the ACCESS cycle
   task automatic do_req(input logic we, input logic [1:0] mode, input logic [15:0] ptr,
                         input logic [5:0] disp, input logic [7:0] wdata, input logic [4:0] rd);
      req_valid = 1'b1;
      req_we    = we;
      req_mode  = mode;
      req_ptr   = ptr;
      req_disp  = disp;
      req_wdata = wdata;
      req_rd    = rd;
      tick();
      req_valid = 1'b0;
   endtask

   int n_acc;

   initial begin
      RST = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_mode = 2'b00;
      req_ptr = '0; req_disp = '0; req_wdata = '0; req_rd = '0;
      d_rdata = 8'hA5; io_rdata = 8'h5A;
      tick(); tick();
      chk("rst_busy", 16'(busy), 16'h0);
      chk("rst_d_re", 16'(d_re), 16'h0);
      chk("rst_d_we", 16'(d_we), 16'h0);
      chk("rst_d_addr", d_addr, 16'h0000);
      chk("rst_ptr_new", ptr_new, 16'h0000);
      chk("rst_rd_data", 16'(rd_data), 16'h0000);
      chk("rst_io_addr", 16'(io_addr), 16'h0000);
      RST = 1'b0;
      tick();

      // Plain SRAM load
      do_req(1'b0, 2'b00, 16'h0100, 6'd0, 8'h00, 5'd7);
      chk("ld0_busy1", 16'(busy), 16'h1);
      chk("ld0_d_re", 16'(d_re), 16'h1);
      chk("ld0_d_we", 16'(d_we), 16'h0);
      chk("ld0_d_addr", d_addr, 16'h0100);
      chk("ld0_io_sel", 16'(io_sel), 16'h0);
      chk("ld0_ptr_we", 16'(ptr_we), 16'h0);
      chk("ld0_rd_we_early", 16'(rd_we), 16'h0);
      tick();
      chk("ld0_busy2", 16'(busy), 16'h1);
      chk("ld0_d_re_off", 16'(d_re), 16'h0);
      chk("ld0_rd_we", 16'(rd_we), 16'h1);
      chk("ld0_rd_data", 16'(rd_data), 16'h00A5);
      chk("ld0_rd_addr", 16'(rd_addr), 16'h0007);
      tick();
      chk("ld0_busy3", 16'(busy), 16'h0);
      chk("ld0_rd_we_off", 16'(rd_we), 16'h0);
      chk("ld0_rd_data_hold", 16'(rd_data), 16'h00A5);

      // Post-increment store wrapping at 0xFFFF
      do_req(1'b1, 2'b01, 16'hFFFF, 6'd0, 8'h3C, 5'd0);
      chk("st1_busy", 16'(busy), 16'h1);
      chk("st1_d_we", 16'(d_we), 16'h1);
      chk("st1_d_re", 16'(d_re), 16'h0);
      chk("st1_d_addr", d_addr, 16'hFFFF);
      chk("st1_d_wdata", 16'(d_wdata), 16'h003C);
      chk("st1_ptr_we", 16'(ptr_we), 16'h1);
      chk("st1_ptr_new", ptr_new, 16'h0000);
      tick();
      chk("st1_busy_off", 16'(busy), 16'h0);
      chk("st1_d_we_off", 16'(d_we), 16'h0);
      chk("st1_ptr_we_off", 16'(ptr_we), 16'h0);
      chk("st1_rd_we", 16'(rd_we), 16'h0);
      tick();
      chk("st1_rd_we_late", 16'(rd_we), 16'h0);

      // Pre-decrement load landing at the top of the I/O region
      do_req(1'b0, 2'b10, 16'h0060, 6'd0, 8'h00, 5'd3);
      chk("ld2_io_sel", 16'(io_sel), 16'h1);
      chk("ld2_d_re", 16'(d_re), 16'h1);
      chk("ld2_d_addr", d_addr, 16'h005F);
      chk("ld2_io_addr", 16'(io_addr), 16'h003F);
      chk("ld2_ptr_we", 16'(ptr_we), 16'h1);
      chk("ld2_ptr_new", ptr_new, 16'h005F);
      tick();
      chk("ld2_rd_we", 16'(rd_we), 16'h1);
      chk("ld2_rd_data", 16'(rd_data), 16'h005A);
      chk("ld2_io_sel_off", 16'(io_sel), 16'h0);
      chk("ld2_ptr_we_off", 16'(ptr_we), 16'h0);
      tick();

      // Displacement load, no pointer writeback
      do_req(1'b0, 2'b11, 16'h0200, 6'd63, 8'h00, 5'd20);
      chk("ld3_d_addr", d_addr, 16'h023F);
      chk("ld3_ptr_we", 16'(ptr_we), 16'h0);
      chk("ld3_ptr_new_hold", ptr_new, 16'h005F);
      chk("ld3_io_sel", 16'(io_sel), 16'h0);
      tick();
      chk("ld3_rd_data", 16'(rd_data), 16'h00A5);
      chk("ld3_rd_addr", 16'(rd_addr), 16'h0014);
      tick();

      // Register-alias load faults and returns zero
      do_req(1'b0, 2'b00, 16'h0005, 6'd0, 8'h00, 5'd9);
      chk("ld4_fault", 16'(addr_fault), 16'h1);
      chk("ld4_d_re", 16'(d_re), 16'h0);
      chk("ld4_d_we", 16'(d_we), 16'h0);
      chk("ld4_io_sel", 16'(io_sel), 16'h0);
      tick();
      chk("ld4_fault_off", 16'(addr_fault), 16'h0);
      chk("ld4_rd_we", 16'(rd_we), 16'h1);
      chk("ld4_rd_data", 16'(rd_data), 16'h0000);
      tick();

      // Pre-decrement store wrapping below zero
      do_req(1'b1, 2'b10, 16'h0000, 6'd0, 8'h77, 5'd0);
      chk("st5_d_we", 16'(d_we), 16'h1);
      chk("st5_d_addr", d_addr, 16'hFFFF);
      chk("st5_ptr_new", ptr_new, 16'hFFFF);
      chk("st5_d_wdata", 16'(d_wdata), 16'h0077);
      tick();

      // Reset during ACCESS discards the load
      do_req(1'b0, 2'b01, 16'h0400, 6'd0, 8'h00, 5'd11);
      chk("rst6_access", 16'(d_re), 16'h1);
      RST = 1'b1;
      tick();
      chk("rst6_busy", 16'(busy), 16'h0);
      chk("rst6_rd_we", 16'(rd_we), 16'h0);
      chk("rst6_ptr_we", 16'(ptr_we), 16'h0);
      chk("rst6_d_addr", d_addr, 16'h0000);
      chk("rst6_ptr_new", ptr_new, 16'h0000);
      chk("rst6_rd_data", 16'(rd_data), 16'h0000);
      chk("rst6_rd_addr", 16'(rd_addr), 16'h0000);
      RST = 1'b0;
      tick();
      chk("rst6_rd_we_late", 16'(rd_we), 16'h0);
      chk("rst6_ptr_we_late", 16'(ptr_we), 16'h0);

      // Store followed at once by a load; the load is ignored while busy
      do_req(1'b1, 2'b00, 16'h0300, 6'd0, 8'h11, 5'd0);
      chk("b2b_st_d_we", 16'(d_we), 16'h1);
      req_valid = 1'b1; req_we = 1'b0; req_mode = 2'b00; req_ptr = 16'h0310; req_rd = 5'd2;
      tick();
      chk("b2b_ignored_busy", 16'(busy), 16'h0);
      chk("b2b_ignored_re", 16'(d_re), 16'h0);
      tick();
      req_valid = 1'b0;
      chk("b2b_ld_d_re", 16'(d_re), 16'h1);
      chk("b2b_ld_d_addr", d_addr, 16'h0310);
      tick(); tick();

      // Held request: one load accepted every three cycles
      req_valid = 1'b1; req_we = 1'b0; req_mode = 2'b00; req_ptr = 16'h0100; req_rd = 5'd1;
      n_acc = 0;
      for (int i = 0; i < 9; i++) begin
         tick();
         if (d_re) n_acc++;
      end
      req_valid = 1'b0;
      chk("held_accept_count", 16'(n_acc), 16'd3);
      tick(); tick(); tick();
      chk("held_idle", 16'(busy), 16'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
